// File: rtl/parity_serializer.sv
// Parallel-to-serial converter: shifts a word out LSB-first, then appends one parity bit.
// Feeds the serial parity detector; even parity returns the detector to state 0 at each frame end.
module parity_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  serial_data,
  output logic                  bit_valid,
  output logic                  frame_end,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         bit_cnt;
  logic                  parity;
  logic                  accept;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Accepting during PARITY lets the next frame start with no idle gap.
  always_comb begin
    state_next  = state;
    in_ready    = (state == IDLE) || (state == PARITY);
    accept      = in_valid && in_ready;
    serial_data = 1'b0;
    bit_valid   = 1'b0;
    frame_end   = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = DATA;
      end
      DATA: begin
        serial_data = shift_reg[0];
        bit_valid   = 1'b1;
        busy        = 1'b1;
        if (bit_cnt == LAST_BIT) state_next = PARITY;
      end
      PARITY: begin
        serial_data = parity ^ ODD_PARITY;
        bit_valid   = 1'b1;
        frame_end   = 1'b1;
        busy        = 1'b1;
        state_next  = accept ? DATA : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      parity    <= 1'b0;
    end else if (accept) begin
      shift_reg <= in_data;
      bit_cnt   <= '0;
      parity    <= 1'b0;
    end else if (state == DATA) begin
      shift_reg <= shift_reg >> 1;
      bit_cnt   <= bit_cnt + 1'b1;
      parity    <= parity ^ shift_reg[0];
    end
  end

endmodule

// File: tb/tb_parity_serializer.sv
// Directed self-checking bench for parity_serializer: even, odd and 1-bit-wide instances.
module tb_parity_serializer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic [0:0] in_data1 = '0;
  logic       in_valid1 = 1'b0;

  logic e_ready, e_serial, e_bv, e_fe, e_busy;
  logic o_ready, o_serial, o_bv, o_fe, o_busy;
  logic w_ready, w_serial, w_bv, w_fe, w_busy;

  int checks = 0;
  int errors = 0;
  logic det_e, det_o;
  logic det_o_exp = 1'b0;

  parity_serializer #(.DATA_WIDTH(8), .ODD_PARITY(1'b0)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(e_ready), .serial_data(e_serial), .bit_valid(e_bv),
    .frame_end(e_fe), .busy(e_busy)
  );

  parity_serializer #(.DATA_WIDTH(8), .ODD_PARITY(1'b1)) dut_odd (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(o_ready), .serial_data(o_serial), .bit_valid(o_bv),
    .frame_end(o_fe), .busy(o_busy)
  );

  parity_serializer #(.DATA_WIDTH(1), .ODD_PARITY(1'b0)) dut_w1 (
    .clock(clock), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(w_ready), .serial_data(w_serial), .bit_valid(w_bv),
    .frame_end(w_fe), .busy(w_busy)
  );

  always #5 clock = ~clock;

  // Downstream detector stand-ins: toggle on every valid '1' bit.
  always @(posedge clock) begin
    if (reset) begin
      det_e <= 1'b0;
      det_o <= 1'b0;
    end else begin
      if (e_bv && e_serial) det_e <= ~det_e;
      if (o_bv && o_serial) det_o <= ~det_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // Entered just after the accept edge; checks bits, parity cycle and the following idle cycle.
  task automatic check_frame(input logic [7:0] w, input logic pe, input logic po,
                             input bit scramble, input string name);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++;
      if ({e_bv, e_serial, e_fe, e_busy, e_ready} !== {1'b1, w[i], 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL %s bit%0d status(bv,ser,fe,busy,rdy): got %b want %b", name, i,
                 {e_bv, e_serial, e_fe, e_busy, e_ready}, {1'b1, w[i], 1'b0, 1'b1, 1'b0});
      end
      checks++;
      if ({o_bv, o_serial} !== {1'b1, w[i]}) begin
        errors++;
        $display("FAIL %s odd bit%0d: got %b want %b", name, i, {o_bv, o_serial}, {1'b1, w[i]});
      end
      if (scramble) in_data = 8'($urandom);
    end
    @(negedge clock);
    checks++;
    if ({e_bv, e_serial, e_fe, e_busy, e_ready} !== {1'b1, pe, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL %s parity status: got %b want %b", name,
               {e_bv, e_serial, e_fe, e_busy, e_ready}, {1'b1, pe, 1'b1, 1'b1, 1'b1});
    end
    checks++;
    if ({o_serial, o_fe} !== {po, 1'b1}) begin
      errors++;
      $display("FAIL %s odd parity: got %b want %b", name, {o_serial, o_fe}, {po, 1'b1});
    end
    det_o_exp = ~det_o_exp;
    @(negedge clock);
    checks++;
    if ({e_bv, e_serial, e_fe, e_busy, e_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL %s idle status: got %b want 00001", name, {e_bv, e_serial, e_fe, e_busy, e_ready});
    end
    checks++;
    if ({det_e, det_o} !== {1'b0, det_o_exp}) begin
      errors++;
      $display("FAIL %s detector(even,odd): got %b want %b", name, {det_e, det_o}, {1'b0, det_o_exp});
    end
  endtask

  task automatic send(input logic [7:0] w, input logic pe, input logic po,
                      input bit scramble, input string name);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clock);
    #1 in_valid = 1'b0;
    check_frame(w, pe, po, scramble, name);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    det_o_exp = 1'b0;
  endtask

  // Reset held with in_valid high; the word is taken at the first edge with reset low.
  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hB4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({e_bv, e_serial, e_fe, e_busy, e_ready, o_bv, o_busy} !== 7'b0000100) begin
        errors++;
        $display("FAIL reset cycle%0d: got %b want 0000100", i,
                 {e_bv, e_serial, e_fe, e_busy, e_ready, o_bv, o_busy});
      end
    end
    reset = 1'b0;
    @(posedge clock);
    #1 in_valid = 1'b0;
    check_frame(8'hB4, 1'b0, 1'b1, 1'b0, "frame_b4");
  endtask

  task automatic test_parity_modes();
    do_reset();
    send(8'h07, 1'b1, 1'b0, 1'b0, "frame_07");
  endtask

  task automatic test_back_to_back();
    logic [17:0] even_bits;
    logic [17:0] odd_bits;
    logic        fe;
    even_bits = 18'b1_00000001_0_11111111;
    odd_bits  = 18'b0_00000001_1_11111111;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clock);
    #1 in_data = 8'h01;
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      fe = (i == 8) || (i == 17);
      checks++;
      if ({e_bv, e_serial, e_fe, e_busy, e_ready} !== {1'b1, even_bits[i], fe, 1'b1, fe}) begin
        errors++;
        $display("FAIL b2b cycle%0d status: got %b want %b", i,
                 {e_bv, e_serial, e_fe, e_busy, e_ready}, {1'b1, even_bits[i], fe, 1'b1, fe});
      end
      checks++;
      if ({o_bv, o_serial} !== {1'b1, odd_bits[i]}) begin
        errors++;
        $display("FAIL b2b odd cycle%0d: got %b want %b", i, {o_bv, o_serial}, {1'b1, odd_bits[i]});
      end
      if (i == 9) in_valid = 1'b0;
    end
    @(negedge clock);
    checks++;
    if ({e_bv, e_busy, e_ready, det_e, det_o} !== {3'b001, 1'b0, det_o_exp}) begin
      errors++;
      $display("FAIL b2b idle(bv,busy,rdy,det_e,det_o): got %b want %b",
               {e_bv, e_busy, e_ready, det_e, det_o}, {3'b001, 1'b0, det_o_exp});
    end
  endtask

  task automatic test_input_stability();
    do_reset();
    send(8'h5A, 1'b0, 1'b1, 1'b1, "stable_5a");
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0] w;
    w = 8'hF0;
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clock);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if ({e_bv, e_serial, e_busy} !== {1'b1, w[i], 1'b1}) begin
        errors++;
        $display("FAIL abort bit%0d: got %b want %b", i, {e_bv, e_serial, e_busy}, {1'b1, w[i], 1'b1});
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      reset = 1'b0;
      det_o_exp = 1'b0;
      checks++;
      if ({e_bv, e_serial, e_fe, e_busy, e_ready, o_fe, o_busy} !== 7'b0000100) begin
        errors++;
        $display("FAIL abort idle%0d: got %b want 0000100", i,
                 {e_bv, e_serial, e_fe, e_busy, e_ready, o_fe, o_busy});
      end
    end
    send(8'h03, 1'b0, 1'b1, 1'b0, "after_abort_03");
  endtask

  task automatic test_width1();
    logic [4:0] exp_status [5];
    exp_status = '{5'b11010, 5'b11111, 5'b10010, 5'b10111, 5'b00001};
    in_valid1 = 1'b1;
    in_data1  = 1'b1;
    @(posedge clock);
    #1 in_data1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if ({w_bv, w_serial, w_fe, w_busy, w_ready} !== exp_status[i]) begin
        errors++;
        $display("FAIL width1 cycle%0d: got %b want %b", i,
                 {w_bv, w_serial, w_fe, w_busy, w_ready}, exp_status[i]);
      end
      if (i == 2) in_valid1 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_parity_modes();
    test_back_to_back();
    test_input_stability();
    test_mid_frame_reset();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
